board_ctrl: RTL and testbench
=============================

BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 SHALL have parameter LAYOUT, default 64'h7766554433221100, holding the card value for board slot i in bits [4i+3:4i], 16 slots, 8 pairs.
REQ-002 SHALL have parameter TURN_CYCLES, default 32'd50_000_000, setting the per-turn time limit in clock cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_move, input, 1, synchronous level button that advances the cursor.
REQ-006 SHALL have port btn_sel, input, 1, synchronous level button that picks the card under the cursor.
REQ-007 SHALL have port x, input, 2, turn result from the downstream turn stage; 2'b01 means a pair was resolved.
REQ-008 SHALL have port par, input, 1, match flag from the downstream stage, valid when x==2'b01.
REQ-009 SHALL have port counter, output, 8, cursor slot index 0..15, zero-extended.
REQ-010 SHALL have port select, output, 1, single-cycle pick pulse.
REQ-011 SHALL have port state, output, 4, the card value at the cursor, LAYOUT[4*counter +: 4], combinational.
REQ-012 SHALL have port empty, output, 1, combinational; high when the cursor slot is unmatched and is not the pending first pick.
REQ-013 SHALL have port player, output, 1, the active player (0 = J1, 1 = J2).
REQ-014 SHALL have port matched, output, 16, the per-slot matched mask.
REQ-015 SHALL have port time_left, output, 32, the remaining cycles in the current turn.
REQ-016 SHALL have port game_over, output, 1, high once all 16 slots are matched.

Function
REQ-017 SHALL detect button rises as btn & ~btn_q, using one registered previous sample per button.
REQ-018 SHALL reset btn_q to 1, so a button held through reset release does not generate a rise.
REQ-019 SHALL implement the phases IDLE (awaiting first pick), PICK2 (awaiting second pick), RESOLVE (awaiting the downstream result) and DONE.
REQ-020 SHALL, on a btn_move rise in IDLE or PICK2, increment counter modulo 16 (15 -> 0); moves are ignored in RESOLVE and DONE.
REQ-021 SHALL, on a btn_sel rise in IDLE or PICK2 with empty==1, assert select for exactly the next cycle.
REQ-022 SHALL ignore a btn_sel rise when empty==0; no pulse is generated and the phase is unchanged.
REQ-023 SHALL give select priority when btn_move and btn_sel rise in the same cycle; the move is discarded and counter is unchanged.
REQ-024 SHALL, on a first pick in IDLE, store first_idx = counter and enter PICK2; on a second pick in PICK2, store second_idx = counter and enter RESOLVE.
REQ-025 SHALL, in RESOLVE, wait an unbounded number of cycles for x==2'b01 and then sample par.
REQ-026 SHALL, when par==1, set matched[first_idx] and matched[second_idx] and keep player unchanged.
REQ-027 SHALL, when par==0, toggle player and leave matched unchanged.
REQ-028 SHALL, after resolution, enter DONE if matched becomes 16'hFFFF; otherwise enter IDLE with time_left reloaded to TURN_CYCLES.
REQ-029 SHALL decrement time_left by 1 per cycle in IDLE and PICK2, and hold it in RESOLVE and DONE.
REQ-030 SHALL, when time_left==1 is decremented in IDLE or PICK2, toggle player, discard any first pick, enter IDLE and reload TURN_CYCLES.
REQ-031 SHALL give timeout priority over a simultaneous pick rise; the pick is discarded and no select pulse is generated.
REQ-032 SHALL, in DONE, assert game_over, never assert select, hold all other outputs, and ignore x values 2'b10 and 2'b11.
REQ-033 SHALL ignore x values other than 2'b01 in every phase.

Reset
REQ-034 SHALL, while rst is high (including mid-turn), force counter=0, select=0, player=0, matched=0, time_left=TURN_CYCLES, game_over=0, phase IDLE, first_idx=second_idx=0 and btn_q=2'b11.

Verification
REQ-035 SHALL verify wrap: 16 btn_move rises from reset -> counter ends at 0, and state tracks LAYOUT at each step.
REQ-036 SHALL verify a match: pick slot 0, move, pick slot 1, drive x=01 with par=1 -> matched=16'h0003, player=0, select pulsed twice for 1 cycle each.
REQ-037 SHALL verify a miss: pick slot 0, then slots 2 and 0 -> the second pick of slot 0 is rejected (empty=0, no pulse); pick slot 2, drive x=01 with par=0 -> player=1, matched=0.
REQ-038 SHALL verify timeout with TURN_CYCLES=10: first pick, then idle -> after 10 cycles from the turn start player toggles, the phase is IDLE and time_left=10.
REQ-039 SHALL verify completion: resolve all 8 pairs with par=1 -> matched=16'hFFFF, game_over=1, and further btn_sel rises give no select.
REQ-040 SHALL verify mid-operation reset: assert rst in RESOLVE with btn_sel held high, then release -> all reset values hold and no select occurs until btn_sel falls and rises again.

Source files
------------

// File: rtl/board_ctrl_if.sv
// Board controller bus: button and turn-result inputs, cursor/board/turn status outputs.
interface board_ctrl_if;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned CARD_W = 4;
   localparam int unsigned SLOTS  = 16;
   localparam int unsigned TIME_W = 32;

   logic              btn_move;
   logic              btn_sel;
   logic [1:0]        x;
   logic              par;
   logic [CNT_W-1:0]  counter;
   logic              select;
   logic [CARD_W-1:0] state;
   logic              empty;
   logic              player;
   logic [SLOTS-1:0]  matched;
   logic [TIME_W-1:0] time_left;
   logic              game_over;

   modport master (
      output btn_move, btn_sel, x, par,
      input  counter, select, state, empty, player, matched, time_left, game_over
   );

   modport slave (
      input  btn_move, btn_sel, x, par,
      output counter, select, state, empty, player, matched, time_left, game_over
   );
endinterface

// File: rtl/board_ctrl.sv
// Memory-game board controller: cursor, two-pick turn sequencing, pair resolution,
// per-turn timeout and player alternation.
module board_ctrl #(
   parameter logic [63:0] LAYOUT      = 64'h7766554433221100,
   parameter logic [31:0] TURN_CYCLES = 32'd50_000_000
) (
   input logic         clk,
   input logic         rst,
   board_ctrl_if.slave bus
);
   localparam int unsigned SLOTS  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned CARD_W = 4;
   localparam int unsigned TIME_W = 32;
   localparam int unsigned BASE_W = 6;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PICK2   = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [1:0] X_RESOLVED = 2'b01;

   logic [1:0]        r_phase;
   logic [IDX_W-1:0]  r_counter;
   logic [IDX_W-1:0]  r_first_idx;
   logic [IDX_W-1:0]  r_second_idx;
   logic [SLOTS-1:0]  r_matched;
   logic              r_player;
   logic [TIME_W-1:0] r_time_left;
   logic              r_select;
   logic              r_game_over;
   logic [1:0]        r_btn_q;

   logic [1:0]        w_phase_nxt;
   logic [IDX_W-1:0]  w_counter_nxt;
   logic [IDX_W-1:0]  w_first_nxt;
   logic [IDX_W-1:0]  w_second_nxt;
   logic [SLOTS-1:0]  w_matched_nxt;
   logic              w_player_nxt;
   logic [TIME_W-1:0] w_time_nxt;
   logic              w_select_nxt;
   logic              w_game_over_nxt;

   logic              w_move_rise;
   logic              w_sel_rise;
   logic              w_active;
   logic              w_timeout;
   logic              w_pending;
   logic              w_empty;
   logic              w_pick;
   logic [SLOTS-1:0]  w_merged;
   logic [BASE_W-1:0] w_base;

   // r_btn_q[0] tracks btn_move, r_btn_q[1] tracks btn_sel
   assign w_move_rise = bus.btn_move & ~r_btn_q[0];
   assign w_sel_rise  = bus.btn_sel  & ~r_btn_q[1];

   assign w_active  = (r_phase == IDLE) || (r_phase == PICK2);
   assign w_timeout = w_active && (r_time_left == TIME_W'(1));

   // The first pick stays pending until its turn is resolved
   assign w_pending = ((r_phase == PICK2) || (r_phase == RESOLVE)) && (r_counter == r_first_idx);
   assign w_empty   = ~r_matched[r_counter] & ~w_pending;
   assign w_pick    = w_active & w_sel_rise & w_empty & ~w_timeout;

   assign w_merged = r_matched | (SLOTS'(1) << r_first_idx) | (SLOTS'(1) << r_second_idx);
   assign w_base   = {r_counter, 2'b00};

   // Next-state and registered-output decode
   always_comb begin
      w_phase_nxt     = r_phase;
      w_counter_nxt   = r_counter;
      w_first_nxt     = r_first_idx;
      w_second_nxt    = r_second_idx;
      w_matched_nxt   = r_matched;
      w_player_nxt    = r_player;
      w_time_nxt      = r_time_left;
      w_select_nxt    = 1'b0;
      w_game_over_nxt = r_game_over;

      case (r_phase)
         IDLE, PICK2: begin
            w_time_nxt = r_time_left - TIME_W'(1);
            if (w_move_rise && !w_sel_rise) begin
               w_counter_nxt = r_counter + IDX_W'(1);
            end
            if (w_timeout) begin
               w_player_nxt = ~r_player;
               w_phase_nxt  = IDLE;
               w_time_nxt   = TURN_CYCLES;
            end else if (w_pick) begin
               w_select_nxt = 1'b1;
               if (r_phase == IDLE) begin
                  w_first_nxt = r_counter;
                  w_phase_nxt = PICK2;
               end else begin
                  w_second_nxt = r_counter;
                  w_phase_nxt  = RESOLVE;
               end
            end
         end

         RESOLVE: begin
            if (bus.x == X_RESOLVED) begin
               if (bus.par) begin
                  w_matched_nxt = w_merged;
                  if (&w_merged) begin
                     w_phase_nxt     = DONE;
                     w_game_over_nxt = 1'b1;
                  end else begin
                     w_phase_nxt = IDLE;
                     w_time_nxt  = TURN_CYCLES;
                  end
               end else begin
                  w_player_nxt = ~r_player;
                  w_phase_nxt  = IDLE;
                  w_time_nxt   = TURN_CYCLES;
               end
            end
         end

         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase      <= IDLE;
         r_counter    <= '0;
         r_first_idx  <= '0;
         r_second_idx <= '0;
         r_matched    <= '0;
         r_player     <= 1'b0;
         r_time_left  <= TURN_CYCLES;
         r_select     <= 1'b0;
         r_game_over  <= 1'b0;
         r_btn_q      <= 2'b11;
      end else begin
         r_phase      <= w_phase_nxt;
         r_counter    <= w_counter_nxt;
         r_first_idx  <= w_first_nxt;
         r_second_idx <= w_second_nxt;
         r_matched    <= w_matched_nxt;
         r_player     <= w_player_nxt;
         r_time_left  <= w_time_nxt;
         r_select     <= w_select_nxt;
         r_game_over  <= w_game_over_nxt;
         r_btn_q      <= {bus.btn_sel, bus.btn_move};
      end
   end

   assign bus.counter   = CNT_W'(r_counter);
   assign bus.select    = r_select;
   assign bus.state     = LAYOUT[w_base +: CARD_W];
   assign bus.empty     = w_empty;
   assign bus.player    = r_player;
   assign bus.matched   = r_matched;
   assign bus.time_left = r_time_left;
   assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: directed scenarios plus random play, every cycle compared
// against a turn-level model of the game.
module tb_board_ctrl;
   localparam logic [63:0] LAY  = 64'h7766554433221100;
   localparam int          TURN = 10;

   logic clk = 1'b0;
   logic rst;

   board_ctrl_if bus ();

   board_ctrl #(
      .LAYOUT      (LAY),
      .TURN_CYCLES (32'(TURN))
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit [3:0]  cursor;
      bit        move_prev;
      bit        sel_prev;
      bit        has_first;
      bit [3:0]  first;
      bit        has_second;
      bit [3:0]  second;
      bit [15:0] mask;
      bit        plr;
      int        tleft;
      bit        pulse;
      bit        over;
   } mdl_t;

   mdl_t m;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [3:0] card(input int k);
      logic [63:0] l;
      l = LAY;
      return l[4*k +: 4];
   endfunction

   function automatic bit mempty(input mdl_t s);
      return !s.mask[s.cursor] && !(s.has_first && s.first == s.cursor);
   endfunction

   function automatic mdl_t mreset();
      mdl_t s;
      s = '0;
      s.move_prev = 1'b1;
      s.sel_prev  = 1'b1;
      s.tleft     = TURN;
      return s;
   endfunction

   // One clock of the game seen at turn level: who is picking, what is pending
   function automatic mdl_t mstep(input mdl_t s, input bit bm, input bit bs,
                                  input bit [1:0] xx, input bit pp);
      mdl_t n;
      bit   mr, sr;
      n = s;
      mr = bm && !s.move_prev;
      sr = bs && !s.sel_prev;
      n.move_prev = bm;
      n.sel_prev  = bs;
      n.pulse     = 1'b0;
      if (!s.over && !s.has_second) begin
         if (mr && !sr) n.cursor = 4'((int'(s.cursor) + 1) % 16);
         if (s.tleft == 1) begin
            n.plr       = !s.plr;
            n.has_first = 1'b0;
            n.tleft     = TURN;
         end else begin
            n.tleft = s.tleft - 1;
            if (sr && mempty(s)) begin
               n.pulse = 1'b1;
               if (!s.has_first) begin
                  n.has_first = 1'b1;
                  n.first     = s.cursor;
               end else begin
                  n.has_second = 1'b1;
                  n.second     = s.cursor;
               end
            end
         end
      end else if (!s.over && xx == 2'b01) begin
         if (pp) begin
            n.mask = s.mask | (16'(1) << s.first) | (16'(1) << s.second);
            if (n.mask == 16'hFFFF) n.over = 1'b1;
            else                    n.tleft = TURN;
         end else begin
            n.plr   = !s.plr;
            n.tleft = TURN;
         end
         n.has_first  = 1'b0;
         n.has_second = 1'b0;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/counter"},   32'(bus.counter),   32'(m.cursor));
      chk({tag, "/select"},    32'(bus.select),    32'(m.pulse));
      chk({tag, "/state"},     32'(bus.state),     32'(card(int'(m.cursor))));
      chk({tag, "/empty"},     32'(bus.empty),     32'(mempty(m)));
      chk({tag, "/player"},    32'(bus.player),    32'(m.plr));
      chk({tag, "/matched"},   32'(bus.matched),   32'(m.mask));
      chk({tag, "/time_left"}, 32'(bus.time_left), 32'(m.tleft));
      chk({tag, "/game_over"}, 32'(bus.game_over), 32'(m.over));
   endtask

   task automatic cyc(input logic bm, input logic bs, input logic [1:0] xx, input logic pp);
      bus.btn_move = bm;
      bus.btn_sel  = bs;
      bus.x        = xx;
      bus.par      = pp;
      m = mstep(m, bm, bs, xx, pp);
      @(posedge clk);
      #1;
      check_all("cyc");
   endtask

   task automatic reset_literals(input string tag);
      chk({tag, "/counter"},   32'(bus.counter),   32'd0);
      chk({tag, "/select"},    32'(bus.select),    32'd0);
      chk({tag, "/player"},    32'(bus.player),    32'd0);
      chk({tag, "/matched"},   32'(bus.matched),   32'd0);
      chk({tag, "/time_left"}, 32'(bus.time_left), 32'(TURN));
      chk({tag, "/game_over"}, 32'(bus.game_over), 32'd0);
   endtask

   // Async assert, hold, release with btn_sel at bs, then one more cycle at bs
   task automatic do_reset(input logic bs);
      bus.btn_move = 1'b0;
      bus.btn_sel  = bs;
      bus.x        = 2'b00;
      bus.par      = 1'b0;
      rst = 1'b1;
      #1;
      m = mreset();
      reset_literals("rst_async");
      check_all("rst_async");
      repeat (2) @(posedge clk);
      #1;
      reset_literals("rst_hold");
      rst = 1'b0;
      cyc(1'b0, bs, 2'b00, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b0;
      bus.btn_move = 1'b0;
      bus.btn_sel  = 1'b0;
      bus.x        = 2'b00;
      bus.par      = 1'b0;
      #2;

      // Cursor wrap through all 16 slots
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 1'b0, 2'b00, 1'b0);
         chk("wrap_state", 32'(bus.state), 32'(card(i % 16)));
         cyc(1'b0, 1'b0, 2'b00, 1'b0);
      end
      chk("wrap_counter", 32'(bus.counter), 32'd0);

      // Matching pair on slots 0 and 1
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("match_pulse1", 32'(bus.select), 32'd1);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      chk("match_pulse1_end", 32'(bus.select), 32'd0);
      chk("match_cursor", 32'(bus.counter), 32'd1);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("match_pulse2", 32'(bus.select), 32'd1);
      cyc(1'b0, 1'b0, 2'b10, 1'b1);
      chk("match_pulse2_end", 32'(bus.select), 32'd0);
      chk("match_x10_ignored", 32'(bus.matched), 32'd0);
      cyc(1'b0, 1'b0, 2'b01, 1'b1);
      chk("match_mask", 32'(bus.matched), 32'h0003);
      chk("match_player", 32'(bus.player), 32'd0);
      chk("match_reload", 32'(bus.time_left), 32'(TURN));

      // Miss: re-pick of the pending slot is rejected, then slot 2 resolves as a miss
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      chk("miss_empty_pending", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("miss_reject", 32'(bus.select), 32'd0);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("miss_pick2", 32'(bus.select), 32'd1);
      cyc(1'b0, 1'b0, 2'b01, 1'b0);
      chk("miss_player", 32'(bus.player), 32'd1);
      chk("miss_mask", 32'(bus.matched), 32'd0);

      // Timeout after a first pick
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      repeat (7) cyc(1'b0, 1'b0, 2'b00, 1'b0);
      chk("tmo_last", 32'(bus.time_left), 32'd1);
      chk("tmo_player_before", 32'(bus.player), 32'd0);
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      chk("tmo_player", 32'(bus.player), 32'd1);
      chk("tmo_reload", 32'(bus.time_left), 32'(TURN));
      chk("tmo_pick_dropped", 32'(bus.empty), 32'd1);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("tmo_fresh_first", 32'(bus.select), 32'd1);
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("tmo_now_pick2", 32'(bus.select), 32'd0);

      // Timeout wins over a simultaneous pick
      do_reset(1'b0);
      repeat (8) cyc(1'b0, 1'b0, 2'b00, 1'b0);
      chk("tmo_prio_last", 32'(bus.time_left), 32'd1);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("tmo_prio_nopulse", 32'(bus.select), 32'd0);
      chk("tmo_prio_player", 32'(bus.player), 32'd1);
      chk("tmo_prio_idle", 32'(bus.empty), 32'd1);

      // Complete the board
      do_reset(1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc(1'b1, 1'b0, 2'b00, 1'b0);
         cyc(1'b0, 1'b1, 2'b00, 1'b0);
         cyc(1'b1, 1'b0, 2'b00, 1'b0);
         cyc(1'b0, 1'b1, 2'b00, 1'b0);
         cyc(1'b0, 1'b0, 2'b01, 1'b1);
      end
      chk("done_mask", 32'(bus.matched), 32'h0000FFFF);
      chk("done_flag", 32'(bus.game_over), 32'd1);
      chk("done_time_held", 32'(bus.time_left), 32'd6);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 2'(i + 1), 1'b1);
         chk("done_no_select", 32'(bus.select), 32'd0);
         cyc(1'b1, 1'b0, 2'b11, 1'b0);
      end
      chk("done_cursor_held", 32'(bus.counter), 32'd15);
      chk("done_player_held", 32'(bus.player), 32'd0);

      // Reset during RESOLVE with btn_sel held through release
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 2'b01, 1'b0);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("mid_pre_player", 32'(bus.player), 32'd1);
      chk("mid_pre_counter", 32'(bus.counter), 32'd3);
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 2'b00, 1'b0);
         chk("mid_held_no_select", 32'(bus.select), 32'd0);
      end
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 2'b00, 1'b0);
      chk("mid_new_rise", 32'(bus.select), 32'd1);

      // Random play, with occasional resets
      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         if (c % 700 == 699) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
